// File: rtl/demux1_2_2bit_reg_if.sv
// Source/sink bundle of the 1-to-2 registered demux.
// master drives source beats and sink readies; slave is the demux itself.
interface demux1_2_2bit_reg_if;
  logic [1:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       selec;
  logic       alt_mode;
  logic [1:0] out0_data;
  logic [1:0] out1_data;
  logic       out0_valid;
  logic       out1_valid;
  logic       out0_ready;
  logic       out1_ready;
  logic [3:0] cnt0;
  logic [3:0] cnt1;

  modport master (
    output in_data, in_valid, selec, alt_mode, out0_ready, out1_ready,
    input  in_ready, out0_data, out1_data, out0_valid, out1_valid, cnt0, cnt1
  );

  modport slave (
    input  in_data, in_valid, selec, alt_mode, out0_ready, out1_ready,
    output in_ready, out0_data, out1_data, out0_valid, out1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux1_2_2bit_reg.sv
// 1-to-2 demux with a one-beat output register per channel, selectable or
// alternating routing, and a modulo-16 delivered-beat counter per channel.

module demux1_2_2bit_reg_ch (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       load_i,
  input  logic [1:0] data_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [1:0] data_o,
  output logic [3:0] cnt_o
);
  typedef struct packed {
    logic       valid;
    logic [1:0] data;
    logic [3:0] cnt;
  } ch_state_t;

  ch_state_t st_q, st_d;
  logic      deliver;

  // Load is applied after delivery so a same-cycle pop+push keeps valid high.
  always_comb begin
    st_d    = st_q;
    deliver = st_q.valid & ready_i;
    if (deliver) begin
      st_d.valid = 1'b0;
      st_d.cnt   = st_q.cnt + 4'd1;
    end
    if (load_i) begin
      st_d.valid = 1'b1;
      st_d.data  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) st_q <= '0;
    else          st_q <= st_d;
  end

  assign valid_o = st_q.valid;
  assign data_o  = st_q.data;
  assign cnt_o   = st_q.cnt;
endmodule

module demux1_2_2bit_reg (
  input  logic                  clk,
  input  logic                  reset_L,
  demux1_2_2bit_reg_if.slave    bus
);
  localparam int NUM_CH = 2;
  localparam int DW     = 2;
  localparam int CW     = 4;

  logic [NUM_CH-1:0]         ch_ready;
  logic [NUM_CH-1:0]         ch_load;
  logic [NUM_CH-1:0]         ch_valid;
  logic [NUM_CH-1:0][DW-1:0] ch_data;
  logic [NUM_CH-1:0][CW-1:0] ch_cnt;

  logic tgt;
  logic accept;
  logic tog_q, tog_d;

  assign ch_ready = {bus.out1_ready, bus.out0_ready};

  // Readiness looks only at the target channel; the other one may stall freely.
  always_comb begin
    tgt          = bus.alt_mode ? tog_q : bus.selec;
    bus.in_ready = reset_L & (~ch_valid[tgt] | ch_ready[tgt]);
    accept       = bus.in_valid & bus.in_ready;
    ch_load      = '0;
    ch_load[tgt] = accept;
    tog_d        = tog_q ^ (accept & bus.alt_mode);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) tog_q <= 1'b0;
    else          tog_q <= tog_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    demux1_2_2bit_reg_ch u_ch (
      .clk     (clk),
      .reset_L (reset_L),
      .load_i  (ch_load[g]),
      .data_i  (bus.in_data),
      .ready_i (ch_ready[g]),
      .valid_o (ch_valid[g]),
      .data_o  (ch_data[g]),
      .cnt_o   (ch_cnt[g])
    );
  end

  assign bus.out0_valid = ch_valid[0];
  assign bus.out1_valid = ch_valid[1];
  assign bus.out0_data  = ch_data[0];
  assign bus.out1_data  = ch_data[1];
  assign bus.cnt0       = ch_cnt[0];
  assign bus.cnt1       = ch_cnt[1];
endmodule

// File: tb/tb_demux1_2_2bit_reg.sv
// Directed scenarios followed by random traffic, compared against a
// queue-based model of the two one-deep channel buffers.
module tb_demux1_2_2bit_reg;
  logic clk = 1'b0;
  logic reset_L;
  demux1_2_2bit_reg_if ifc ();

  demux1_2_2bit_reg dut (.clk(clk), .reset_L(reset_L), .bus(ifc));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: each channel is a queue of undelivered beats, plus last loaded data.
  logic [1:0] q0[$], q1[$];
  logic [1:0] last0 = 2'b00, last1 = 2'b00;
  int         c0 = 0, c1 = 0;
  bit         m_tog = 1'b0;
  logic [1:0] log0[$], log1[$];
  logic       rdy;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [1:0] d, input bit sel, input bit alt,
                      input bit r0, input bit r1, input bit rst, output logic rdy_o);
    bit t, mrdy, acc;
    ifc.in_valid   = v;
    ifc.in_data    = d;
    ifc.selec      = sel;
    ifc.alt_mode   = alt;
    ifc.out0_ready = r0;
    ifc.out1_ready = r1;
    reset_L        = rst;
    #1;
    t     = alt ? m_tog : sel;
    mrdy  = rst && (((t ? q1.size() : q0.size()) == 0) || (t ? r1 : r0));
    rdy_o = ifc.in_ready;
    chk("in_ready", {7'd0, rdy_o}, {7'd0, mrdy});
    if (rst && ifc.out0_valid === 1'b1 && r0) log0.push_back(ifc.out0_data);
    if (rst && ifc.out1_valid === 1'b1 && r1) log1.push_back(ifc.out1_data);
    @(posedge clk);
    if (!rst) begin
      q0.delete(); q1.delete();
      last0 = 2'b00; last1 = 2'b00; c0 = 0; c1 = 0; m_tog = 1'b0;
    end else begin
      acc = v && mrdy;
      if (q0.size() > 0 && r0) begin void'(q0.pop_front()); c0 = (c0 + 1) % 16; end
      if (q1.size() > 0 && r1) begin void'(q1.pop_front()); c1 = (c1 + 1) % 16; end
      if (acc) begin
        if (t) begin q1.push_back(d); last1 = d; end
        else   begin q0.push_back(d); last0 = d; end
        if (alt) m_tog = !m_tog;
      end
    end
    @(negedge clk);
    chk("out0_valid", {7'd0, ifc.out0_valid}, {7'd0, q0.size() > 0});
    chk("out1_valid", {7'd0, ifc.out1_valid}, {7'd0, q1.size() > 0});
    chk("out0_data",  {6'd0, ifc.out0_data},  {6'd0, last0});
    chk("out1_data",  {6'd0, ifc.out1_data},  {6'd0, last1});
    chk("cnt0",       {4'd0, ifc.cnt0},       8'(c0));
    chk("cnt1",       {4'd0, ifc.cnt1},       8'(c1));
  endtask

  initial begin
    // Reset held with a pending source beat.
    step(1, 2'b11, 0, 0, 1, 1, 0, rdy);
    chk("rst_in_ready", {7'd0, rdy}, 8'd0);
    step(1, 2'b11, 0, 0, 1, 1, 0, rdy);
    chk("rst_in_ready2", {7'd0, rdy}, 8'd0);
    chk("rst_v0", {7'd0, ifc.out0_valid}, 8'd0);
    chk("rst_v1", {7'd0, ifc.out1_valid}, 8'd0);
    chk("rst_d0", {6'd0, ifc.out0_data}, 8'd0);
    chk("rst_cnt1", {4'd0, ifc.cnt1}, 8'd0);

    // Single beat to out0, first cycle after reset.
    step(1, 2'b10, 0, 0, 1, 1, 1, rdy);
    chk("sel0_v0", {7'd0, ifc.out0_valid}, 8'd1);
    chk("sel0_d0", {6'd0, ifc.out0_data}, 8'h2);
    chk("sel0_v1", {7'd0, ifc.out1_valid}, 8'd0);
    step(0, 2'b00, 0, 0, 1, 1, 1, rdy);
    chk("sel0_cnt0", {4'd0, ifc.cnt0}, 8'd1);

    // Stall on out1, then simultaneous deliver + load.
    step(1, 2'b01, 1, 0, 1, 0, 1, rdy);
    chk("stall_acc", {7'd0, rdy}, 8'd1);
    step(1, 2'b11, 1, 0, 1, 0, 1, rdy);
    chk("stall_in_ready", {7'd0, rdy}, 8'd0);
    chk("stall_hold_d1", {6'd0, ifc.out1_data}, 8'h1);
    step(1, 2'b11, 0, 1, 1, 0, 1, rdy);  // routing change while stalled
    chk("stall_mode_d1", {6'd0, ifc.out1_data}, 8'h1);
    step(1, 2'b11, 1, 0, 1, 1, 1, rdy);
    chk("swap_in_ready", {7'd0, rdy}, 8'd1);
    chk("swap_d1", {6'd0, ifc.out1_data}, 8'h3);
    chk("swap_v1", {7'd0, ifc.out1_valid}, 8'd1);
    chk("swap_cnt1", {4'd0, ifc.cnt1}, 8'd1);
    step(0, 2'b00, 1, 0, 1, 1, 1, rdy);

    // Alternating routing, back-to-back.
    step(0, 2'b00, 0, 0, 1, 1, 0, rdy);
    log0.delete(); log1.delete();
    for (int i = 0; i < 4; i++) step(1, 2'(i), 0, 1, 1, 1, 1, rdy);
    step(0, 2'b00, 0, 1, 1, 1, 1, rdy);
    chk("alt_n0", 8'(log0.size()), 8'd2);
    chk("alt_n1", 8'(log1.size()), 8'd2);
    if (log0.size() == 2 && log1.size() == 2) begin
      chk("alt_l0a", {6'd0, log0[0]}, 8'h0);
      chk("alt_l0b", {6'd0, log0[1]}, 8'h2);
      chk("alt_l1a", {6'd0, log1[0]}, 8'h1);
      chk("alt_l1b", {6'd0, log1[1]}, 8'h3);
    end
    chk("alt_cnt0", {4'd0, ifc.cnt0}, 8'd2);
    chk("alt_cnt1", {4'd0, ifc.cnt1}, 8'd2);
    step(1, 2'b01, 1, 1, 0, 0, 1, rdy);  // toggle back at 0 -> out0
    chk("alt_tog_v0", {7'd0, ifc.out0_valid}, 8'd1);
    chk("alt_tog_d0", {6'd0, ifc.out0_data}, 8'h1);
    chk("alt_tog_v1", {7'd0, ifc.out1_valid}, 8'd0);

    // Counter wrap.
    step(0, 2'b00, 0, 0, 1, 1, 0, rdy);
    for (int i = 0; i < 17; i++) step(1, 2'($urandom), 0, 0, 1, 1, 1, rdy);
    step(0, 2'b00, 0, 0, 1, 1, 1, rdy);
    chk("wrap_cnt0", {4'd0, ifc.cnt0}, 8'd1);
    chk("wrap_cnt1", {4'd0, ifc.cnt1}, 8'd0);

    // Reset discards a stalled beat.
    step(1, 2'b11, 0, 0, 0, 0, 1, rdy);
    step(0, 2'b00, 0, 0, 0, 0, 1, rdy);
    chk("hold_d0", {6'd0, ifc.out0_data}, 8'h3);
    step(1, 2'b01, 0, 0, 0, 0, 0, rdy);
    chk("rst2_v0", {7'd0, ifc.out0_valid}, 8'd0);
    chk("rst2_d0", {6'd0, ifc.out0_data}, 8'd0);
    chk("rst2_cnt0", {4'd0, ifc.cnt0}, 8'd0);
    step(1, 2'b10, 1, 1, 0, 0, 1, rdy);
    chk("rst2_tog_v0", {7'd0, ifc.out0_valid}, 8'd1);
    chk("rst2_tog_v1", {7'd0, ifc.out1_valid}, 8'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++)
      step(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), $urandom_range(39) != 0, rdy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
